// File: rtl/router_wb_pkg.sv
// router_wb_pkg
// Shared definitions for the ALU write-back router and the operand router.
// Holds the destination-select encodings and small decode helpers that say
// which temp registers a given destination writes.
package router_wb_pkg;

  // Destination select carried alongside every ALU result.
  typedef enum logic [1:0] {
    DST_BANK = 2'b00,
    DST_RQ   = 2'b01,
    DST_RD   = 2'b10,
    DST_QD   = 2'b11
  } dst_sel_e;

  // True when the destination includes the RQ temp register.
  function automatic logic dstLoadsRq(input dst_sel_e sel);
    return (sel == DST_RQ) || (sel == DST_QD);
  endfunction

  // True when the destination includes the RD temp register.
  function automatic logic dstLoadsRd(input dst_sel_e sel);
    return (sel == DST_RD) || (sel == DST_QD);
  endfunction

endpackage

// File: rtl/router_wb_hold.sv
// wb_hold_reg
// One-entry valid/ready holding register for the Data Bank write port.
// Loads a payload, holds it stable while the consumer stalls, retires it
// when the consumer is ready, and can be flushed.
//
// Ports:
//   clk_i      clock, all updates on the rising edge
//   rst_i      synchronous active-high reset, clears valid and payload
//   load_i     capture data_i this cycle (caller guarantees can_load_o)
//   flush_i    drop the held entry; payload holds, valid clears
//   data_i     payload to capture
//   ready_i    consumer accepts the held entry this cycle
//   valid_o    held entry is valid
//   data_o     held payload
//   can_load_o register is free now or frees up at this edge
module wb_hold_reg #(
  parameter int PW = 29
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic [PW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o,
  output logic          can_load_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q,  data_d;

  // A retire and a new load can share an edge, which gives one entry per
  // cycle of throughput without a second buffer slot.
  assign can_load_o = ~valid_q | ready_i;

  // Next-state: flush wins over retire/load; a load in the retire cycle
  // overwrites the retired entry and keeps valid asserted.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
      if (load_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/router_wb.sv
// router_wb
// Write-back router at the ALU output. Accepts one result per cycle over a
// valid/ready handshake and steers it to the Data Bank write port (through
// a one-entry holding register), the RQ temp, the RD temp, or both temps.
// Also registers zero/negative flags of the last accepted result.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   res_valid_i  ALU result valid
//   res_ready_o  router can accept a result this cycle
//   res_data_i   ALU result word
//   res_addr_i   Data Bank address (BANK destination only)
//   dst_sel_i    00=BANK 01=RQ 10=RD 11=RQ+RD
//   flush_i      drop pending bank write, block acceptance
//   wr_en_o      Data Bank write request (registered)
//   wr_addr_o    Data Bank write address (registered)
//   wr_data_o    Data Bank write data (registered)
//   wr_ready_i   Data Bank accepts the write this cycle
//   RQ_o, RD_o   temp registers feeding the operand router
//   z_flag_o     last accepted result was zero
//   n_flag_o     MSB of last accepted result
module router_wb
  import router_wb_pkg::*;
#(
  parameter int W  = 24,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          res_valid_i,
  output logic          res_ready_o,
  input  logic [W-1:0]  res_data_i,
  input  logic [AW-1:0] res_addr_i,
  input  logic [1:0]    dst_sel_i,
  input  logic          flush_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [W-1:0]  wr_data_o,
  input  logic          wr_ready_i,
  output logic [W-1:0]  RQ_o,
  output logic [W-1:0]  RD_o,
  output logic          z_flag_o,
  output logic          n_flag_o
);

  dst_sel_e        dstSel;
  logic            holdFree;
  logic            acceptNow;
  logic            bankLoad;
  logic [AW+W-1:0] holdPayload;

  logic [W-1:0] rq_q, rq_d;
  logic [W-1:0] rd_q, rd_d;
  logic         zFlag_q, zFlag_d;
  logic         nFlag_q, nFlag_d;

  assign dstSel = dst_sel_e'(dst_sel_i);

  // Readiness only looks at the bank holding register, even for temp
  // destinations, so results always complete in issue order.
  assign res_ready_o = ~rst_i & ~flush_i & holdFree;
  assign acceptNow   = res_valid_i & res_ready_o;
  assign bankLoad    = acceptNow & (dstSel == DST_BANK);

  wb_hold_reg #(
    .PW(AW + W)
  ) u_hold (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (bankLoad),
    .flush_i    (flush_i),
    .data_i     ({res_addr_i, res_data_i}),
    .ready_i    (wr_ready_i),
    .valid_o    (wr_en_o),
    .data_o     (holdPayload),
    .can_load_o (holdFree)
  );

  assign wr_addr_o = holdPayload[AW+W-1:W];
  assign wr_data_o = holdPayload[W-1:0];

  // Temp registers and flags only move on an accepted result; flags track
  // every accepted result whatever its destination.
  always_comb begin
    rq_d    = rq_q;
    rd_d    = rd_q;
    zFlag_d = zFlag_q;
    nFlag_d = nFlag_q;
    if (acceptNow) begin
      if (dstLoadsRq(dstSel)) rq_d = res_data_i;
      if (dstLoadsRd(dstSel)) rd_d = res_data_i;
      zFlag_d = (res_data_i == '0);
      nFlag_d = res_data_i[W-1];
    end
  end

  // Temp and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rq_q    <= '0;
      rd_q    <= '0;
      zFlag_q <= 1'b0;
      nFlag_q <= 1'b0;
    end else begin
      rq_q    <= rq_d;
      rd_q    <= rd_d;
      zFlag_q <= zFlag_d;
      nFlag_q <= nFlag_d;
    end
  end

  assign RQ_o     = rq_q;
  assign RD_o     = rd_q;
  assign z_flag_o = zFlag_q;
  assign n_flag_o = nFlag_q;

endmodule

// File: tb/tb_router_wb.sv
// tb_router_wb
// Self-checking bench for router_wb: directed scenarios followed by a
// randomized run compared against a behavioural model of the router.
module tb_router_wb;
  import router_wb_pkg::*;

  localparam int W  = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          resValid;
  logic          resReady;
  logic [W-1:0]  resData;
  logic [AW-1:0] resAddr;
  logic [1:0]    dstSel;
  logic          flush;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [W-1:0]  wrData;
  logic          wrReady;
  logic [W-1:0]  rq;
  logic [W-1:0]  rd;
  logic          zFlag;
  logic          nFlag;

  int compared   = 0;
  int mismatched = 0;

  router_wb #(.W(W), .AW(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .res_valid_i(resValid),
    .res_ready_o(resReady),
    .res_data_i (resData),
    .res_addr_i (resAddr),
    .dst_sel_i  (dstSel),
    .flush_i    (flush),
    .wr_en_o    (wrEn),
    .wr_addr_o  (wrAddr),
    .wr_data_o  (wrData),
    .wr_ready_i (wrReady),
    .RQ_o       (rq),
    .RD_o       (rd),
    .z_flag_o   (zFlag),
    .n_flag_o   (nFlag)
  );

  always #5 clk = ~clk;

  // Drive one cycle worth of inputs; the caller waits #1 before sampling
  // the combinational ready, then calls tick.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d,
                               input logic [AW-1:0] a, input logic [1:0] s,
                               input logic f, input logic wr);
    rst = r; resValid = v; resData = d; resAddr = a; dstSel = s;
    flush = f; wrReady = wr;
  endtask

  // Advance past the next rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] g;
    for (int i = 0; i < 3; i++) begin
      g = $urandom;
      applyStimulus(1'b1, 1'b1, g[W-1:0], g[AW-1:0], g[1:0], g[31], 1'b1);
      #1;
      compared++;
      if (resReady !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_ready cyc%0d: got %b want 0", i, resReady);
      end
      tick();
    end
    compared++;
    if ({wrEn, wrAddr, wrData, rq, rd, zFlag, nFlag} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got wrEn=%b addr=%h data=%h rq=%h rd=%h z=%b n=%b want all 0",
               wrEn, wrAddr, wrData, rq, rd, zFlag, nFlag);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    #1;
    compared++;
    if (resReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", resReady);
    end
    tick();
  endtask

  task automatic test_temp_load();
    doReset();
    applyStimulus(1'b0, 1'b1, 24'h123456, 5'd0, DST_RQ, 1'b0, 1'b0);
    tick();
    compared++;
    if (rq !== 24'h123456 || rd !== 24'h0) begin
      mismatched++;
      $display("[TB] FAIL temp_rq: got rq=%h rd=%h want rq=123456 rd=000000", rq, rd);
    end
    applyStimulus(1'b0, 1'b1, 24'hFFFFFF, 5'd0, DST_QD, 1'b0, 1'b0);
    tick();
    compared++;
    if (rq !== 24'hFFFFFF || rd !== 24'hFFFFFF || nFlag !== 1'b1 || zFlag !== 1'b0 || wrEn !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL temp_qd: got rq=%h rd=%h n=%b z=%b wrEn=%b want FFFFFF FFFFFF 1 0 0",
               rq, rd, nFlag, zFlag, wrEn);
    end
  endtask

  task automatic test_bank_stall();
    doReset();
    applyStimulus(1'b0, 1'b1, 24'h00ABCD, 5'd5, DST_BANK, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 24'h777777, 5'd9, DST_BANK, 1'b0, 1'b0);
      #1;
      compared++;
      if (resReady !== 1'b0 || wrEn !== 1'b1 || wrAddr !== 5'd5 || wrData !== 24'h00ABCD) begin
        mismatched++;
        $display("[TB] FAIL stall_hold cyc%0d: got rdy=%b wrEn=%b addr=%0d data=%h want 0 1 5 00ABCD",
                 i, resReady, wrEn, wrAddr, wrData);
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, DST_BANK, 1'b0, 1'b1);
    #1;
    compared++;
    if (resReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_release_ready: got %b want 1", resReady);
    end
    tick();
    compared++;
    if (wrEn !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_retire: got wrEn=%b want 0", wrEn);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [4];
    logic [31:0]  g;
    doReset();
    for (int i = 0; i < 4; i++) begin
      g = $urandom;
      d[i] = g[W-1:0];
      applyStimulus(1'b0, 1'b1, d[i], AW'(i), DST_BANK, 1'b0, 1'b1);
      #1;
      compared++;
      if (resReady !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready %0d: got %b want 1", i, resReady);
      end
      tick();
      compared++;
      if (wrEn !== 1'b1 || wrAddr !== AW'(i) || wrData !== d[i]) begin
        mismatched++;
        $display("[TB] FAIL b2b_write %0d: got en=%b addr=%0d data=%h want 1 %0d %h",
                 i, wrEn, wrAddr, wrData, i, d[i]);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, '0, DST_BANK, 1'b0, 1'b1);
    tick();
    compared++;
    if (wrEn !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain: got wrEn=%b want 0", wrEn);
    end
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(1'b0, 1'b1, 24'h314159, 5'd0, DST_RQ, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 24'h00BEEF, 5'd7, DST_BANK, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 24'h000000, 5'd3, DST_RQ, 1'b1, 1'b0);
    #1;
    compared++;
    if (resReady !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_ready: got %b want 0", resReady);
    end
    tick();
    compared++;
    if (wrEn !== 1'b0 || wrAddr !== 5'd7 || wrData !== 24'h00BEEF || rq !== 24'h314159 || zFlag !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_state: got en=%b addr=%0d data=%h rq=%h z=%b want 0 7 00BEEF 314159 0",
               wrEn, wrAddr, wrData, rq, zFlag);
    end
  endtask

  task automatic test_zero_and_reset_stall();
    doReset();
    applyStimulus(1'b0, 1'b1, 24'h800001, 5'd0, DST_RD, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 24'h000000, 5'd0, DST_RD, 1'b0, 1'b0);
    tick();
    compared++;
    if (rd !== 24'h0 || zFlag !== 1'b1 || nFlag !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_result: got rd=%h z=%b n=%b want 000000 1 0", rd, zFlag, nFlag);
    end
    applyStimulus(1'b0, 1'b1, 24'h55AA55, 5'd12, DST_BANK, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 24'h123123, 5'd1, DST_BANK, 1'b0, 1'b0);
    #1;
    compared++;
    if (resReady !== 1'b0 || wrEn !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_stall_pre: got rdy=%b wrEn=%b want 0 1", resReady, wrEn);
    end
    tick();
    compared++;
    if (wrEn !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_stall_clear: got wrEn=%b want 0", wrEn);
    end
  endtask

  // Randomized run against a rule-level model of the router.
  task automatic test_random();
    logic          mPend = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic [W-1:0]  mData = '0;
    logic [W-1:0]  mRq = '0, mRd = '0;
    logic          mZ = 1'b0, mN = 1'b0;
    logic          expReady, acc;
    logic [31:0]   g;
    logic [W-1:0]  d;
    logic          r, v, f, wr;
    logic [1:0]    s;
    doReset();
    for (int i = 0; i < 400; i++) begin
      g = $urandom;
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = '1;
        default: d = g[W-1:0];
      endcase
      r  = ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 1) == 0);
      s  = 2'($urandom_range(0, 3));
      applyStimulus(r, v, d, g[31:27], s, f, wr);
      #1;
      expReady = !r && !f && (!mPend || wr);
      compared++;
      if (resReady !== expReady) begin
        mismatched++;
        $display("[TB] FAIL rand_ready cyc%0d: got %b want %b", i, resReady, expReady);
      end
      acc = v && expReady;
      if (r) begin
        mPend = 1'b0; mAddr = '0; mData = '0; mRq = '0; mRd = '0; mZ = 1'b0; mN = 1'b0;
      end else begin
        if (f || (mPend && wr)) mPend = 1'b0;
        if (acc) begin
          if (s == 2'b00) begin
            mPend = 1'b1; mAddr = g[31:27]; mData = d;
          end
          if (s[0]) mRq = d;
          if (s[1]) mRd = d;
          mZ = (d == 0);
          mN = d[W-1];
        end
      end
      tick();
      compared++;
      if ({wrEn, wrAddr, wrData, rq, rd, zFlag, nFlag} !== {mPend, mAddr, mData, mRq, mRd, mZ, mN}) begin
        mismatched++;
        $display("[TB] FAIL rand_state cyc%0d: got en=%b a=%h d=%h rq=%h rd=%h z=%b n=%b want en=%b a=%h d=%h rq=%h rd=%h z=%b n=%b",
                 i, wrEn, wrAddr, wrData, rq, rd, zFlag, nFlag, mPend, mAddr, mData, mRq, mRd, mZ, mN);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_temp_load();
    test_bank_stall();
    test_back_to_back();
    test_flush();
    test_zero_and_reset_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
